// File: rtl/adder_accum_pkg.sv
// Shared types and defaults for the adder accumulator controller.
// Holds the FSM state enum and the default datapath widths.
package adder_accum_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LEN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_accum_ctrl.sv
// Drives an external adder with {acc, operand} for an N-operand job.
// Optional sticky carry flag on io_out_overflow: ADDER_ACCUM_OVERFLOW_EN.
module adder_accum_ctrl
    import adder_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start,
    input  logic [LEN_W-1:0] io_len,
    output logic             io_busy,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_data,
    output logic [WIDTH-1:0] io_add_a,
    output logic [WIDTH-1:0] io_add_b,
    input  logic [WIDTH-1:0] io_add_sum,
    output logic             io_out_valid,
    input  logic             io_out_ready,
`ifdef ADDER_ACCUM_OVERFLOW_EN
    output logic             io_out_overflow,
`endif
    output logic [WIDTH-1:0] io_out_sum
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [LEN_W-1:0] r_rem;
    logic             w_hs;
    logic             w_start;
    logic             w_last;

    assign w_hs    = io_in_valid & io_in_ready;
    assign w_start = (r_state == ST_IDLE) & io_start;
    assign w_last  = (r_rem == LEN_W'(1));

    // State register; reset abandons any job in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: start, last handshake, result accepted
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (io_start)
                    w_next = (io_len == '0) ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (w_hs && w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (io_out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; adder ports driven in every state
    always_comb begin
        io_busy      = (r_state != ST_IDLE);
        io_in_ready  = (r_state == ST_ACCUM);
        io_out_valid = (r_state == ST_DONE);
        io_add_a     = r_acc;
        io_add_b     = io_in_data;
        io_out_sum   = r_acc;
    end

    // Accumulator and remaining count; acc is kept after DONE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_rem <= '0;
        end else if (w_start) begin
            r_acc <= '0;
            r_rem <= io_len;
        end else if (w_hs) begin
            r_acc <= io_add_sum;
            r_rem <= r_rem - LEN_W'(1);
        end
    end

`ifdef ADDER_ACCUM_OVERFLOW_EN
    logic r_ovf;

    // Sticky carry-out: sum below the a operand means the add wrapped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       r_ovf <= 1'b0;
        else if (w_start) r_ovf <= 1'b0;
        else if (w_hs && (io_add_sum < io_add_a))
            r_ovf <= 1'b1;
    end

    assign io_out_overflow = r_ovf;
`endif

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Self-checking bench for adder_accum_ctrl with a behavioural adder.
// Reference model is a plain running sum with carry tracking.
module tb_adder_accum_ctrl;

    localparam int WIDTH = 32;
    localparam int LEN_W = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             io_start = 1'b0;
    logic [LEN_W-1:0] io_len = '0;
    logic             io_busy;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_data = '0;
    logic [WIDTH-1:0] io_add_a;
    logic [WIDTH-1:0] io_add_b;
    logic [WIDTH-1:0] io_add_sum;
    logic             io_out_valid;
    logic             io_out_ready = 1'b0;
    logic [WIDTH-1:0] io_out_sum;
    logic             io_out_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] q_ops[$];

    // Behavioural combinational adder, modulo 2^WIDTH
    assign io_add_sum = io_add_a + io_add_b;

`ifndef ADDER_ACCUM_OVERFLOW_EN
    assign io_out_overflow = 1'b0;
`endif

    adder_accum_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_start     (io_start),
        .io_len       (io_len),
        .io_busy      (io_busy),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_data   (io_in_data),
        .io_add_a     (io_add_a),
        .io_add_b     (io_add_b),
        .io_add_sum   (io_add_sum),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
`ifdef ADDER_ACCUM_OVERFLOW_EN
        .io_out_overflow (io_out_overflow),
`endif
        .io_out_sum   (io_out_sum)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // gap: 0 none, 1 alternate, 2 random; poke: io_start during ACCUM
    task automatic run_job(input string name, input int gap,
                           input int rdly, input bit poke);
        logic [WIDTH-1:0] acc;
        logic [WIDTH:0]   wide;
        bit               ovf;
        int               len;
        int               idx;
        int               cyc;
        bit               stall;
        len = q_ops.size();
        acc = '0;
        ovf = 1'b0;
        foreach (q_ops[i]) begin
            wide = {1'b0, acc} + {1'b0, q_ops[i]};
            ovf  = ovf | wide[WIDTH];
            acc  = wide[WIDTH-1:0];
        end
        io_start = 1'b1;
        io_len   = LEN_W'(len);
        step();
        io_start = 1'b0;
        check({name, ":busy_start"}, 64'(io_busy), 64'd1);
        idx = 0;
        cyc = 0;
        wide = '0;
        while (idx < len && cyc < 1000) begin
            case (gap)
                1:       stall = (cyc % 2) == 1;
                2:       stall = ($urandom_range(0, 2) == 0);
                default: stall = 1'b0;
            endcase
            if (poke && cyc == 0) begin
                stall    = 1'b1;
                io_start = 1'b1;
                io_len   = LEN_W'(9);
            end
            io_in_valid = !stall;
            io_in_data  = stall ? WIDTH'($urandom) : q_ops[idx];
            check({name, ":in_ready"}, 64'(io_in_ready), 64'd1);
            check({name, ":add_a"}, 64'(io_add_a), 64'(wide[WIDTH-1:0]));
            check({name, ":add_b"}, 64'(io_add_b), 64'(io_in_data));
            step();
            io_start = 1'b0;
            if (!stall) begin
                wide = {1'b0, wide[WIDTH-1:0] + q_ops[idx]};
                idx++;
            end
            if (idx < len)
                check({name, ":no_early_valid"}, 64'(io_out_valid), 64'd0);
            cyc++;
        end
        io_in_valid = 1'b0;
        if (cyc >= 1000) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s:op_timeout: observed %0d expected <1000", name, cyc);
        end
        check({name, ":out_valid"}, 64'(io_out_valid), 64'd1);
        check({name, ":in_ready_done"}, 64'(io_in_ready), 64'd0);
        check({name, ":busy_done"}, 64'(io_busy), 64'd1);
        check({name, ":out_sum"}, 64'(io_out_sum), 64'(acc));
`ifdef ADDER_ACCUM_OVERFLOW_EN
        check({name, ":overflow"}, 64'(io_out_overflow), 64'(ovf));
`endif
        for (int k = 0; k < rdly; k++) begin
            step();
            check({name, ":hold_valid"}, 64'(io_out_valid), 64'd1);
            check({name, ":hold_sum"}, 64'(io_out_sum), 64'(acc));
        end
        io_out_ready = 1'b1;
        step();
        io_out_ready = 1'b0;
        check({name, ":valid_drop"}, 64'(io_out_valid), 64'd0);
        check({name, ":busy_idle"}, 64'(io_busy), 64'd0);
        check({name, ":acc_kept"}, 64'(io_out_sum), 64'(acc));
        step();
        check({name, ":idle_ready"}, 64'(io_in_ready), 64'd0);
    endtask

    initial begin
        #3;
        check("rst:busy", 64'(io_busy), 64'd0);
        check("rst:in_ready", 64'(io_in_ready), 64'd0);
        check("rst:out_valid", 64'(io_out_valid), 64'd0);
        check("rst:out_sum", 64'(io_out_sum), 64'd0);
        check("rst:overflow", 64'(io_out_overflow), 64'd0);
        step();
        reset = 1'b1;
        step();
        check("idle:busy", 64'(io_busy), 64'd0);

        q_ops = '{32'd5, 32'd7, 32'd9};
        run_job("basic", 0, 0, 1'b0);

        q_ops = '{};
        run_job("zero", 0, 0, 1'b0);

        q_ops = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_job("bp", 1, 5, 1'b0);

        q_ops = '{32'hFFFF_FFFF, 32'h0000_0002};
        run_job("wrap", 0, 1, 1'b0);

        q_ops = '{32'd1, 32'd1};
        run_job("nowrap", 0, 0, 1'b0);

        // Abort a len=5 job after two operands
        io_start = 1'b1;
        io_len   = LEN_W'(5);
        step();
        io_start    = 1'b0;
        io_in_valid = 1'b1;
        io_in_data  = 32'd100;
        step();
        io_in_data  = 32'd200;
        step();
        io_in_valid = 1'b0;
        check("abort:acc2", 64'(io_add_a), 64'd300);
        reset = 1'b0;
        #1;
        check("abort:busy", 64'(io_busy), 64'd0);
        check("abort:out_valid", 64'(io_out_valid), 64'd0);
        check("abort:acc", 64'(io_out_sum), 64'd0);
        step();
        reset = 1'b1;
        step();
        check("abort:idle_valid", 64'(io_out_valid), 64'd0);
        check("abort:idle_busy", 64'(io_busy), 64'd0);

        q_ops = '{32'd42};
        run_job("after_rst", 0, 0, 1'b0);

        q_ops = '{32'd11, 32'd22};
        run_job("poke", 0, 0, 1'b1);

        for (int j = 0; j < 8; j++) begin
            int n;
            n = $urandom_range(1, 9);
            q_ops = '{};
            for (int i = 0; i < n; i++)
                q_ops.push_back(($urandom_range(0, 1) == 1) ?
                                WIDTH'($urandom) : WIDTH'($urandom_range(0, 999)));
            run_job("rand", 2, $urandom_range(0, 3), 1'(j % 3 == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_accum_ctrl.md
Name: adder_accum_ctrl

Overview:
- Initiator side of the combinational adder interface (a, b in; sum out).
- Accepts a job of N operands over a valid/ready stream and drives the external adder with {accumulator, operand}.
- Captures each returned sum into the accumulator, then presents the final total on a valid/ready result port.
- Sits between a software-visible job front end and an adder wrapper instance.

Parameters:
- WIDTH, 32, operand/sum/accumulator width in bits.
- LEN_W, 16, width of the job length field; max job length 2^LEN_W-1.

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_start  input  1  job start pulse; sampled only in IDLE.
- io_len  input  LEN_W  number of operands in the job; sampled with io_start.
- io_busy  output  1  high in any state other than IDLE.
- io_in_valid  input  1  operand valid.
- io_in_ready  output  1  operand ready.
- io_in_data  input  WIDTH  operand.
- io_add_a  output  WIDTH  to adder a; equals accumulator.
- io_add_b  output  WIDTH  to adder b; equals io_in_data.
- io_add_sum  input  WIDTH  from adder sum (combinational, same cycle).
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  result ready.
- io_out_sum  output  WIDTH  final accumulated sum.

Behaviour:
- States: IDLE, ACCUM, DONE (encoding is implementation choice).
- Reset (reset low, async): state=IDLE, acc=0, remaining=0, io_busy=0, io_in_ready=0, io_out_valid=0, io_out_sum=0.
- IDLE, on io_start:
  - acc<=0, remaining<=io_len.
  - If io_len==0: go to DONE (result 0).
  - Otherwise: go to ACCUM.
- IDLE, without io_start: stays in IDLE; io_in_ready=0.
- ACCUM:
  - io_in_ready=1.
  - io_add_a=acc and io_add_b=io_in_data, driven combinationally.
  - Handshake (valid&ready): acc<=io_add_sum, remaining<=remaining-1.
  - Handshake with remaining==1: go to DONE.
  - No handshake: hold.
- DONE:
  - io_out_valid=1, io_out_sum=acc; both held stable until accepted.
  - io_out_ready=1: go to IDLE, io_out_valid deasserts next cycle; acc retained until the next start.
- io_start outside IDLE is ignored; io_len is not re-sampled.
- Latency: first operand may be accepted the cycle after io_start; io_out_valid rises the cycle after the last operand handshake.
- Throughput: one operand per cycle.
- Arithmetic: the adder is modulo 2^WIDTH; wrap-around is passed through unmodified.
- io_add_a/io_add_b are driven in every state; io_add_sum is ignored outside ACCUM handshakes.
- Reset mid-job: immediate return to IDLE, partial sum discarded, no result emitted.
- Max length 2^LEN_W-1: remaining must not underflow.

Optional Feature:
- Macro ADDER_ACCUM_OVERFLOW_EN.
- Defined:
  - Adds output io_out_overflow (1 bit), a sticky flag cleared on start.
  - Set on any ACCUM handshake where io_add_sum < io_add_a (unsigned carry-out).
  - Valid alongside io_out_sum; reset value 0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package adder_accum_pkg holds:
  - state enum type (IDLE, ACCUM, DONE);
  - default WIDTH/LEN_W constants.
- No sub-module needed. The adder is external, reached through io_add_*; the bench supplies a behavioural adder.

Test Plan:
- Basic job: start len=3, operands 5, 7, 9 with valid held high → io_out_sum=21, io_out_valid 1 cycle after 3rd handshake, io_busy high throughout.
- Zero length: start len=0 → DONE next cycle, io_out_sum=0, no io_in_ready assertion.
- Backpressure and gaps: len=4, operands 1..4 with valid toggling every other cycle; io_out_ready low for 5 cycles → io_out_sum=10 held stable, returns to IDLE after ready.
- Wrap-around: len=2, operands 0xFFFFFFFF, 0x00000002 → io_out_sum=0x00000001; with ADDER_ACCUM_OVERFLOW_EN, io_out_overflow=1; next job 1+1 → overflow=0.
- Reset mid-job: len=5, after 2 operands assert reset low for 1 cycle → IDLE, io_busy=0, no io_out_valid; new job len=1 operand 42 → 42.
- Start while busy: io_start with io_len=9 during ACCUM of a len=2 job → ignored; job completes after 2 operands with the correct sum.
